// File: rtl/opseq_pkg.sv
// rtl/opseq_pkg.sv - shared defaults and state encoding for the operand sequencer
package opseq_pkg;

  localparam int SIZE_DATA_DEF = 16;
  localparam int DB_CYCLES_DEF = 16;

  localparam logic [2:0] ST_GET_A = 3'd0;
  localparam logic [2:0] ST_WR_A  = 3'd1;
  localparam logic [2:0] ST_GET_B = 3'd2;
  localparam logic [2:0] ST_WR_B  = 3'd3;
  localparam logic [2:0] ST_EXEC1 = 3'd4;
  localparam logic [2:0] ST_EXEC2 = 3'd5;
  localparam logic [2:0] ST_SHOW  = 3'd6;

  typedef enum logic [2:0] {
    GET_A = ST_GET_A,
    WR_A  = ST_WR_A,
    GET_B = ST_GET_B,
    WR_B  = ST_WR_B,
    EXEC1 = ST_EXEC1,
    EXEC2 = ST_EXEC2,
    SHOW  = ST_SHOW
  } state_e;

endpackage

// File: rtl/btn_cond.sv
// rtl/btn_cond.sv - button synchronizer, optional debounce (OPSEQ_DEBOUNCE_EN), rising-edge press
module btn_cond
  import opseq_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic level;
  logic level_prev_q;

  // Two-flop synchronizer bringing the raw button into the clock domain
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef OPSEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          lvl_q;
  logic          lvl_d;

  // Level follows the synchronized input only after it has disagreed for DB_CYCLES cycles in a row
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        lvl_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce counter and filtered level
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign level = lvl_q;
`else
  assign level = sync2_q;
`endif

  // Previous conditioned level for rising-edge detection
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      level_prev_q <= 1'b0;
    end else begin
      level_prev_q <= level;
    end
  end

  assign press_o = level & ~level_prev_q;

endmodule

// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - operand load / execute sequencer; debounce via OPSEQ_DEBOUNCE_EN
module operand_sequencer
  import opseq_pkg::*;
#(
  parameter int size_data = SIZE_DATA_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [size_data-1:0] SW,
  input  logic [2:0]           OP,
  input  logic                 BTN,
  output logic [size_data-1:0] DIN,
  output logic                 WE,
  output logic                 W1,
  output logic [2:0]           MS,
  input  logic [size_data-1:0] ALU_IN,
  output logic [size_data-1:0] RESULT,
  output logic                 RES_VALID,
  output logic                 BUSY
);

  logic press;

  state_e               state_q, state_d;
  logic [size_data-1:0] din_q, din_d;
  logic [2:0]           ms_q, ms_d;
  logic [size_data-1:0] result_q, result_d;
  logic                 res_valid_q, res_valid_d;

  btn_cond #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_cond (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .btn_i  (BTN),
    .press_o(press)
  );

  // Next-state and register updates; presses outside GET_A/GET_B/SHOW fall through unused
  always_comb begin
    state_d     = state_q;
    din_d       = din_q;
    ms_d        = ms_q;
    result_d    = result_q;
    res_valid_d = res_valid_q;
    case (state_q)
      GET_A: begin
        if (press) begin
          state_d = WR_A;
          din_d   = SW;
        end
      end
      WR_A:  state_d = GET_B;
      GET_B: begin
        if (press) begin
          state_d = WR_B;
          din_d   = SW;
          ms_d    = OP;
        end
      end
      WR_B:  state_d = EXEC1;
      EXEC1: state_d = EXEC2;
      EXEC2: begin
        state_d     = SHOW;
        result_d    = ALU_IN;
        res_valid_d = 1'b1;
      end
      SHOW: begin
        if (press) begin
          state_d     = GET_A;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= GET_A;
      din_q       <= '0;
      ms_q        <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      din_q       <= din_d;
      ms_q        <= ms_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign DIN       = din_q;
  assign MS        = ms_q;
  assign RESULT    = result_q;
  assign RES_VALID = res_valid_q;
  assign WE        = (state_q == WR_A) || (state_q == WR_B);
  assign W1        = (state_q == WR_B);
  assign BUSY      = (state_q == WR_A) || (state_q == WR_B) ||
                     (state_q == EXEC1) || (state_q == EXEC2);

endmodule
